mem_rt_arbiter: RTL and testbench
=================================

# mem_rt_arbiter

Per-ray-tracer-core arbiter upstream of the main memory block. It merges NUM_REQ client request streams, such as the ray fetch unit, stack spill unit and result writer, onto that core's single 128-bit main-memory port (we/re/addr/data/rdy). It grants one client at a time in round-robin order and holds the address and write data stable for the whole access. It captures the 128-bit read word when the memory signals ready and returns it to the granted client, with a watchdog that aborts hung accesses.

## Interface
- NUM_REQ, 4: number of client ports, 2..8.
- TIMEOUT, 64: maximum number of WAIT cycles before an access is aborted, at least 8.
- clk  in  1  single clock; all logic is on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid[NUM_REQ]  in  1  client request pending; held until accepted.
- req_we[NUM_REQ]  in  1  1 = write, 0 = read.
- req_addr[NUM_REQ]  in  32  byte address; bits [21:16] select the thread, [13:2] the word.
- req_wdata[NUM_REQ]  in  128  write data.
- req_ready[NUM_REQ]  out  1  one-hot accept strobe.
- resp_valid[NUM_REQ]  out  1  one-cycle completion pulse to the granted client.
- resp_rdata  out  128  shared read data; valid only while a resp_valid bit is high.
- resp_err  out  1  high together with resp_valid when the access timed out.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  128  memory write data.
- mem_rdy  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  128  memory read data; valid in the mem_rdy cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: if any req_valid is set, assert req_ready for the round-robin winner, latch its we/addr/wdata and grant index, then go to ISSUE.
  - ISSUE: drive mem_we = latched we and mem_re = ~latched we for exactly one cycle, clear the watchdog, then go to WAIT.
  - WAIT: when mem_rdy is seen, latch mem_rdata into resp_rdata and go to RESP. If the watchdog reaches TIMEOUT, set resp_err, clear resp_rdata to 0 and go to RESP.
  - RESP: pulse resp_valid[grant], advance the RR pointer to grant, then go to IDLE.
- Round-robin arbitration:
  - Search starts at (ptr+1) mod NUM_REQ and wraps.
  - ptr resets to NUM_REQ-1, so client 0 wins first after reset.
  - A single requester is granted every pass.
- req_ready is combinational from req_valid and ptr, gated by IDLE, and at most one bit is high.
- mem_addr and mem_wdata are registered. They hold the latched values from ISSUE through the end of RESP and are 0 in IDLE.
- mem_we and mem_re are never high in the same cycle and are never high outside ISSUE.
- For writes, resp_rdata takes whatever mem_rdata shows at mem_rdy; the client ignores it.
- mem_rdy outside WAIT is ignored.
- Watchdog: an 8-bit counter that increments every WAIT cycle and saturates.
- Changes on req_* lines after acceptance have no effect on the access in flight.

## Timing
- Reset values: state IDLE, ptr NUM_REQ-1, and all outputs 0 (req_ready is 0 because reset forces IDLE with no grant; it follows req_valid once rst drops).
- Reset asserted mid-access aborts immediately: no resp_valid is issued and the memory strobes drop asynchronously.
- Accept at edge E0. mem_we/mem_re are high from E0 to E1.
- If mem_rdy is sampled high at edge Ek, resp_valid is high from Ek to Ek+1 and req_ready can assert again from Ek+1.
- For a memory that asserts rdy 4 cycles after the strobe, client-to-response latency is 6 cycles, with 7 cycles between successive grants.
- mem_rdy arriving in the same cycle the watchdog reaches TIMEOUT takes priority: the access completes with resp_err = 0.
- Throughput is one outstanding access per core, with no pipelining.

## Test plan
- Single read: client 1 requests a read at addr 0x0003_0010 while memory returns 0xDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233 4 cycles after mem_re -> one mem_re pulse with mem_addr held until RESP, then resp_valid[1] for one cycle with that data and resp_err = 0.
- Write: client 2 writes 0x1111_2222_3333_4444_5555_6666_7777_8888 at 0x0000_0100 -> one mem_we pulse, mem_wdata stable through WAIT, resp_valid[2] pulses, and mem_re stays 0 throughout.
- Fairness: all 4 clients hold req_valid continuously -> grants go 0,1,2,3,0,1 and no client waits more than 3 grants.
- Timeout: mem_rdy is never asserted -> resp_valid[g] and resp_err go high TIMEOUT+1 cycles after ISSUE with resp_rdata = 0, and the next grant proceeds normally.
- Reset mid-WAIT: assert rst 2 cycles after mem_re -> all outputs go to 0 at once, no resp_valid is issued, and after rst is released client 0 is granted first.
- Stray mem_rdy in IDLE with no requests pending -> no resp_valid and busy stays 0.

Source files
------------

// File: rtl/mem_rt_arbiter.sv
// mem_rt_arbiter: round-robin arbiter that merges NUM_REQ client request
// streams of one ray-tracer core onto its single 128-bit main-memory port.
// One access is in flight at a time. A watchdog aborts accesses whose
// memory never answers.
module mem_rt_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ-1:0][31:0]  req_addr,
   input  logic [NUM_REQ-1:0][127:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [127:0]              resp_rdata,
   output logic                      resp_err,
   output logic                      mem_we,
   output logic                      mem_re,
   output logic [31:0]               mem_addr,
   output logic [127:0]              mem_wdata,
   input  logic                      mem_rdy,
   input  logic [127:0]              mem_rdata,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   // The watchdog holds TIMEOUT-1 in the last WAIT cycle before an abort.
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] grant_q;
   logic             lat_we_q;
   logic             err_q;
   logic [7:0]       wdog_q;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;

   // Round-robin search that starts one past the last granted client and wraps.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // State register; reset drops any access in flight immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic plus strobes, accept and completion outputs.
   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      resp_valid = '0;
      resp_err   = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      busy       = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = ISSUE;
               if (!rst) begin
                  req_ready[win_idx] = 1'b1;
               end
            end
         end
         ISSUE: begin
            mem_we  = lat_we_q;
            mem_re  = ~lat_we_q;
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_rdy || (wdog_q >= WD_LIMIT)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid[grant_q] = 1'b1;
            resp_err            = err_q;
            state_d             = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Access datapath: latch the winner, run the watchdog, capture read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= IDX_W'(NUM_REQ - 1);
         grant_q    <= '0;
         lat_we_q   <= 1'b0;
         err_q      <= 1'b0;
         wdog_q     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_rdata <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  grant_q   <= win_idx;
                  lat_we_q  <= req_we[win_idx];
                  mem_addr  <= req_addr[win_idx];
                  mem_wdata <= req_wdata[win_idx];
               end
            end
            ISSUE: begin
               wdog_q <= '0;
               err_q  <= 1'b0;
            end
            WAIT: begin
               if (wdog_q != 8'hFF) begin
                  wdog_q <= wdog_q + 8'd1;
               end
               if (mem_rdy) begin
                  resp_rdata <= mem_rdata;
                  err_q      <= 1'b0;
               end else if (wdog_q >= WD_LIMIT) begin
                  resp_rdata <= '0;
                  err_q      <= 1'b1;
               end
            end
            RESP: begin
               ptr_q     <= grant_q;
               mem_addr  <= '0;
               mem_wdata <= '0;
            end
            default: begin
               ptr_q <= ptr_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_rt_arbiter.sv
// tb_mem_rt_arbiter: directed bench for mem_rt_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_mem_rt_arbiter;

   localparam int NREQ = 4;
   localparam int TO   = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_we;
   logic [NREQ-1:0][31:0]  req_addr;
   logic [NREQ-1:0][127:0] req_wdata;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        resp_valid;
   logic [127:0]           resp_rdata;
   logic                   resp_err;
   logic                   mem_we;
   logic                   mem_re;
   logic [31:0]            mem_addr;
   logic [127:0]           mem_wdata;
   logic                   mem_rdy;
   logic [127:0]           mem_rdata;
   logic                   busy;

   int testsRun    = 0;
   int testsFailed = 0;

   localparam logic [127:0] RD_DATA  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
   localparam logic [127:0] WR_DATA  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] WR_JUNK  = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0000;
   localparam logic [127:0] RD_DATA2 = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_CAFE_F00D;
   localparam logic [127:0] RD_DATA3 = 128'h5555_AAAA_5555_AAAA_0000_FFFF_0000_FFFF;

   always #5 clk = ~clk;

   mem_rt_arbiter #(
      .NUM_REQ(NREQ),
      .TIMEOUT(TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdy   (mem_rdy),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] c, input logic v, input logic we,
                                input logic [31:0] a, input logic [127:0] d);
      req_valid[c] = v;
      req_we[c]    = we;
      req_addr[c]  = a;
      req_wdata[c] = d;
   endtask

   task automatic stepCycle();
      @(negedge clk);
   endtask

   initial begin
      logic [NREQ-1:0] fairExp [6];
      fairExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      mem_rdy   = 1'b0;
      mem_rdata = '0;
      #1;
      checkOutput("rst_busy", 128'(busy), 128'd0);
      checkOutput("rst_ready", 128'(req_ready), 128'd0);
      checkOutput("rst_strobes", 128'({mem_we, mem_re}), 128'd0);
      checkOutput("rst_addr", 128'(mem_addr), 128'd0);
      checkOutput("rst_resp", 128'({resp_valid, resp_err}), 128'd0);
      checkOutput("rst_rdata", resp_rdata, 128'd0);
      stepCycle();
      stepCycle();
      rst = 1'b0;
      stepCycle();

      // Single read from client 1, memory answers four cycles after the strobe.
      applyStimulus(2'd1, 1'b1, 1'b0, 32'h0003_0010, '0);
      #1;
      checkOutput("rd_ready", 128'(req_ready), 128'b0010);
      stepCycle();
      applyStimulus(2'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, '0);
      checkOutput("rd_strobe", 128'({mem_we, mem_re}), 128'b01);
      checkOutput("rd_addr_issue", 128'(mem_addr), 128'h0003_0010);
      checkOutput("rd_busy", 128'(busy), 128'd1);
      stepCycle();
      checkOutput("rd_strobe_wait", 128'({mem_we, mem_re}), 128'b00);
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("rd_addr_wait", 128'(mem_addr), 128'h0003_0010);
      checkOutput("rd_noresp_wait", 128'(resp_valid), 128'd0);
      mem_rdy   = 1'b1;
      mem_rdata = RD_DATA;
      stepCycle();
      mem_rdy   = 1'b0;
      mem_rdata = 128'h1;
      checkOutput("rd_resp_valid", 128'(resp_valid), 128'b0010);
      checkOutput("rd_resp_data", resp_rdata, RD_DATA);
      checkOutput("rd_resp_err", 128'(resp_err), 128'd0);
      checkOutput("rd_addr_resp", 128'(mem_addr), 128'h0003_0010);
      stepCycle();
      checkOutput("rd_idle_resp", 128'(resp_valid), 128'd0);
      checkOutput("rd_idle_addr", 128'(mem_addr), 128'd0);
      checkOutput("rd_idle_busy", 128'(busy), 128'd0);

      // Write from client 2; request lines change after acceptance.
      applyStimulus(2'd2, 1'b1, 1'b1, 32'h0000_0100, WR_DATA);
      #1;
      checkOutput("wr_ready", 128'(req_ready), 128'b0100);
      stepCycle();
      applyStimulus(2'd2, 1'b0, 1'b0, 32'h0000_0BAD, WR_JUNK);
      checkOutput("wr_strobe", 128'({mem_we, mem_re}), 128'b10);
      checkOutput("wr_wdata_issue", mem_wdata, WR_DATA);
      checkOutput("wr_addr_issue", 128'(mem_addr), 128'h0000_0100);
      stepCycle();
      checkOutput("wr_strobe_wait", 128'({mem_we, mem_re}), 128'b00);
      checkOutput("wr_wdata_wait", mem_wdata, WR_DATA);
      mem_rdy   = 1'b1;
      mem_rdata = RD_DATA2;
      stepCycle();
      mem_rdy = 1'b0;
      checkOutput("wr_resp_valid", 128'(resp_valid), 128'b0100);
      checkOutput("wr_resp_err", 128'(resp_err), 128'd0);
      checkOutput("wr_re_resp", 128'(mem_re), 128'd0);
      stepCycle();
      checkOutput("wr_idle_wdata", mem_wdata, 128'd0);

      // Stray mem_rdy in IDLE with nothing pending.
      mem_rdy = 1'b1;
      stepCycle();
      checkOutput("stray_resp0", 128'(resp_valid), 128'd0);
      checkOutput("stray_busy0", 128'(busy), 128'd0);
      stepCycle();
      checkOutput("stray_resp1", 128'(resp_valid), 128'd0);
      checkOutput("stray_busy1", 128'(busy), 128'd0);
      mem_rdy = 1'b0;

      // Timeout on client 0: memory never answers.
      applyStimulus(2'd0, 1'b1, 1'b0, 32'h0001_0040, '0);
      #1;
      checkOutput("to_ready", 128'(req_ready), 128'b0001);
      stepCycle();
      applyStimulus(2'd0, 1'b0, 1'b0, '0, '0);
      checkOutput("to_strobe", 128'({mem_we, mem_re}), 128'b01);
      for (int k = 0; k < TO; k++) begin
         stepCycle();
      end
      checkOutput("to_early_resp", 128'(resp_valid), 128'd0);
      checkOutput("to_early_busy", 128'(busy), 128'd1);
      stepCycle();
      checkOutput("to_resp_valid", 128'(resp_valid), 128'b0001);
      checkOutput("to_resp_err", 128'(resp_err), 128'd1);
      checkOutput("to_resp_data", resp_rdata, 128'd0);
      stepCycle();
      checkOutput("to_idle_err", 128'(resp_err), 128'd0);

      // Next access after the timeout proceeds normally (client 1).
      applyStimulus(2'd1, 1'b1, 1'b0, 32'h0002_0004, '0);
      #1;
      checkOutput("post_to_ready", 128'(req_ready), 128'b0010);
      stepCycle();
      applyStimulus(2'd1, 1'b0, 1'b0, '0, '0);
      stepCycle();
      mem_rdy   = 1'b1;
      mem_rdata = RD_DATA2;
      stepCycle();
      mem_rdy = 1'b0;
      checkOutput("post_to_valid", 128'(resp_valid), 128'b0010);
      checkOutput("post_to_err", 128'(resp_err), 128'd0);
      checkOutput("post_to_data", resp_rdata, RD_DATA2);
      stepCycle();

      // mem_rdy in the very cycle the watchdog expires wins (client 2).
      applyStimulus(2'd2, 1'b1, 1'b0, 32'h0004_0008, '0);
      #1;
      checkOutput("edge_ready", 128'(req_ready), 128'b0100);
      stepCycle();
      applyStimulus(2'd2, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < TO; k++) begin
         stepCycle();
      end
      checkOutput("edge_no_early", 128'(resp_valid), 128'd0);
      mem_rdy   = 1'b1;
      mem_rdata = RD_DATA3;
      stepCycle();
      mem_rdy = 1'b0;
      checkOutput("edge_valid", 128'(resp_valid), 128'b0100);
      checkOutput("edge_err", 128'(resp_err), 128'd0);
      checkOutput("edge_data", resp_rdata, RD_DATA3);
      stepCycle();

      // Reset two cycles after the read strobe of client 3.
      applyStimulus(2'd3, 1'b1, 1'b0, 32'h0005_0010, '0);
      #1;
      checkOutput("rstw_ready", 128'(req_ready), 128'b1000);
      stepCycle();
      checkOutput("rstw_strobe", 128'(mem_re), 128'd1);
      stepCycle();
      stepCycle();
      rst     = 1'b1;
      mem_rdy = 1'b1;
      #1;
      checkOutput("rstw_strobes", 128'({mem_we, mem_re}), 128'd0);
      checkOutput("rstw_addr", 128'(mem_addr), 128'd0);
      checkOutput("rstw_busy", 128'(busy), 128'd0);
      checkOutput("rstw_ready_gated", 128'(req_ready), 128'd0);
      checkOutput("rstw_resp", 128'(resp_valid), 128'd0);
      stepCycle();
      checkOutput("rstw_resp_hold", 128'(resp_valid), 128'd0);
      rst     = 1'b0;
      mem_rdy = 1'b0;
      applyStimulus(2'd3, 1'b0, 1'b0, '0, '0);
      stepCycle();
      checkOutput("rstw_after_resp", 128'(resp_valid), 128'd0);
      checkOutput("rstw_after_busy", 128'(busy), 128'd0);

      // Fairness: all clients request continuously; client 0 first after reset.
      for (int c = 0; c < NREQ; c++) begin
         applyStimulus(2'(c), 1'b1, 1'b0, 32'(c) << 4, '0);
      end
      for (int k = 0; k < 6; k++) begin
         #1;
         checkOutput($sformatf("fair_ready%0d", k), 128'(req_ready), 128'(fairExp[k]));
         stepCycle();
         stepCycle();
         mem_rdy   = 1'b1;
         mem_rdata = 128'(k + 7);
         stepCycle();
         mem_rdy = 1'b0;
         checkOutput($sformatf("fair_resp%0d", k), 128'(resp_valid), 128'(fairExp[k]));
         stepCycle();
      end
      req_valid = '0;
      stepCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
